// File: rtl/operand_stage_pkg.sv
// Shared constants, one-hot instruction bit positions and FSM encoding for the
// operand stage.
package operand_stage_pkg;
  localparam int XLEN      = 32;
  localparam int INSTR_W   = 37;
  localparam int OP_ADD    = 0;
  localparam int IMM_OP_LO = 10;
  localparam int IMM_OP_HI = 18;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;
endpackage

// File: rtl/operand_stage_if.sv
// Decode -> operand stage -> ALU handshake bundle, plus bypass and flush inputs.
interface operand_stage_if #(
  parameter int XLEN    = operand_stage_pkg::XLEN,
  parameter int INSTR_W = operand_stage_pkg::INSTR_W
);
  logic               in_valid, in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [XLEN-1:0]    in_rs1_val, in_rs2_val, in_imm;
  logic [4:0]         in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic               fwd_ex_valid, fwd_wb_valid;
  logic [4:0]         fwd_ex_rd, fwd_wb_rd;
  logic [XLEN-1:0]    fwd_ex_data, fwd_wb_data;
  logic               flush;
  logic               out_valid, out_ready;
  logic [XLEN-1:0]    out_v1, out_v2;
  logic [INSTR_W-1:0] out_instr;
  logic [4:0]         out_rd;

  modport master (
    output in_valid, in_instr, in_rs1_val, in_rs2_val, in_imm,
           in_rs1_addr, in_rs2_addr, in_rd_addr,
           fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
           fwd_wb_valid, fwd_wb_rd, fwd_wb_data, flush, out_ready,
    input  in_ready, out_valid, out_v1, out_v2, out_instr, out_rd
  );

  modport slave (
    input  in_valid, in_instr, in_rs1_val, in_rs2_val, in_imm,
           in_rs1_addr, in_rs2_addr, in_rd_addr,
           fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
           fwd_wb_valid, fwd_wb_rd, fwd_wb_data, flush, out_ready,
    output in_ready, out_valid, out_v1, out_v2, out_instr, out_rd
  );
endinterface

// File: rtl/operand_stage_fwd.sv
// Bypass priority for one source operand: x0 is zero, then ALU result, then
// writeback, then register file.
module operand_fwd import operand_stage_pkg::*; #(
  parameter int XLEN = operand_stage_pkg::XLEN
) (
  input  logic [4:0]      rs_i,
  input  logic [XLEN-1:0] rf_i,
  input  logic            ex_valid_i,
  input  logic [4:0]      ex_rd_i,
  input  logic [XLEN-1:0] ex_data_i,
  input  logic            wb_valid_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic [XLEN-1:0] val_o
);
  always_comb begin
    val_o = rf_i;
    if (rs_i == 5'd0)                        val_o = '0;
    else if (ex_valid_i && ex_rd_i == rs_i)  val_o = ex_data_i;
    else if (wb_valid_i && wb_rd_i == rs_i)  val_o = wb_data_i;
  end
endmodule

// File: rtl/operand_stage.sv
// Operand stage: resolves bypassed operands on acceptance and holds them in a
// two-entry (main + skid) buffer that drives the ALU straight from registers.
module operand_stage import operand_stage_pkg::*; #(
  parameter int XLEN    = operand_stage_pkg::XLEN,
  parameter int INSTR_W = operand_stage_pkg::INSTR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  operand_stage_if.slave bus
);
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [4:0]         rd;
    logic [XLEN-1:0]    v1;
    logic [XLEN-1:0]    v2;
  } entry_t;

  state_t          state_q;
  logic            in_ready_q, out_valid_q;
  entry_t          main_q, skid_q, new_e;
  logic [XLEN-1:0] rs1_res, rs2_res;
  logic            in_fire, out_fire;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  operand_fwd #(.XLEN(XLEN)) u_fwd_rs1 (
    .rs_i(bus.in_rs1_addr), .rf_i(bus.in_rs1_val),
    .ex_valid_i(bus.fwd_ex_valid), .ex_rd_i(bus.fwd_ex_rd), .ex_data_i(bus.fwd_ex_data),
    .wb_valid_i(bus.fwd_wb_valid), .wb_rd_i(bus.fwd_wb_rd), .wb_data_i(bus.fwd_wb_data),
    .val_o(rs1_res)
  );

  operand_fwd #(.XLEN(XLEN)) u_fwd_rs2 (
    .rs_i(bus.in_rs2_addr), .rf_i(bus.in_rs2_val),
    .ex_valid_i(bus.fwd_ex_valid), .ex_rd_i(bus.fwd_ex_rd), .ex_data_i(bus.fwd_ex_data),
    .wb_valid_i(bus.fwd_wb_valid), .wb_rd_i(bus.fwd_wb_rd), .wb_data_i(bus.fwd_wb_data),
    .val_o(rs2_res)
  );

  always_comb begin
    new_e.instr = bus.in_instr;
    new_e.rd    = bus.in_rd_addr;
    new_e.v1    = rs1_res;
    new_e.v2    = (|bus.in_instr[IMM_OP_HI:IMM_OP_LO]) ? bus.in_imm : rs2_res;
  end

  // Handshake outputs are registered alongside the state so neither ready nor
  // valid depends combinationally on the other side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else if (bus.flush) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          in_ready_q <= 1'b1;
          if (in_fire) begin
            main_q      <= new_e;
            state_q     <= ST_FULL;
            out_valid_q <= 1'b1;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_q <= new_e;
          end else if (in_fire) begin
            skid_q     <= new_e;
            state_q    <= ST_SKID;
            in_ready_q <= 1'b0;
          end else if (out_fire) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            main_q     <= skid_q;
            state_q    <= ST_FULL;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_v1    = main_q.v1;
  assign bus.out_v2    = main_q.v2;
  assign bus.out_instr = main_q.instr;
  assign bus.out_rd    = main_q.rd;
endmodule
